// File: rtl/hilo_hazard_ctrl.sv
// hilo_hazard_ctrl: HI/LO hazard controller that sits beside the ID stage.
// Tracks pending HI/LO writers through the post-ID stages, picks the bypass
// source for MFHI/MFLO and stalls ID/EX while a multi-cycle MULT/DIV runs.
//
// Ports:
//   clk, rst_n         clock, synchronous active-low reset
//   id_valid           ID holds a real instruction
//   id_op, id_func     ID opcode / funct
//   stall_in           external ID stall (ID content does not advance)
//   flush              kill the ID instruction
//   hi_sel, lo_sel     bypass select: 0 = architectural reg, k = stage k result
//   stall_out          freeze ID and EX (equals md_busy)
//   md_busy            MULT/DIV still executing in EX
module hilo_hazard_ctrl #(
    parameter int unsigned STAGES  = 3,
    parameter int unsigned MUL_LAT = 4,
    parameter int unsigned DIV_LAT = 16,
    localparam int unsigned SELW   = ($clog2(STAGES + 1) < 1) ? 1 : $clog2(STAGES + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            id_valid,
    input  logic [5:0]      id_op,
    input  logic [5:0]      id_func,
    input  logic            stall_in,
    input  logic            flush,
    output logic [SELW-1:0] hi_sel,
    output logic [SELW-1:0] lo_sel,
    output logic            stall_out,
    output logic            md_busy
);

    localparam int unsigned CNTW = 6;

    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] F_MFHI     = 6'b010000;
    localparam logic [5:0] F_MTHI     = 6'b010001;
    localparam logic [5:0] F_MFLO     = 6'b010010;
    localparam logic [5:0] F_MTLO     = 6'b010011;

    localparam logic [CNTW-1:0] MUL_CNT = CNTW'(MUL_LAT - 1);
    localparam logic [CNTW-1:0] DIV_CNT = CNTW'(DIV_LAT - 1);

    // Bit 0 of the flag vectors is stage 1 (EX), bit k-1 is stage k.
    localparam logic [STAGES-1:0] S1 = STAGES'(1);
    localparam logic [STAGES-1:0] S2 = STAGES'(2);

    logic [STAGES-1:0] hi_v, hi_v_nxt;
    logic [STAGES-1:0] lo_v, lo_v_nxt;
    logic [CNTW-1:0]   cnt,  cnt_nxt;

    logic is_special, is_mfhi, is_mflo, is_mthi, is_mtlo, is_mul, is_div;
    logic dec_hi, dec_lo, enter;

    // ID decode
    assign is_special = (id_op == OP_SPECIAL);
    assign is_mfhi    = is_special && (id_func == F_MFHI);
    assign is_mflo    = is_special && (id_func == F_MFLO);
    assign is_mthi    = is_special && (id_func == F_MTHI);
    assign is_mtlo    = is_special && (id_func == F_MTLO);
    assign is_mul     = is_special && (id_func[5:1] == 5'b01100);
    assign is_div     = is_special && (id_func[5:1] == 5'b01101);
    assign dec_hi     = is_mthi || is_mul || is_div;
    assign dec_lo     = is_mtlo || is_mul || is_div;

    assign md_busy    = (cnt != '0);
    assign stall_out  = md_busy;

    // ID instruction actually moves into EX this cycle
    assign enter = id_valid && !stall_in && !flush && !md_busy;

    // Lowest set flag = youngest writer; returns its stage number or 0
    function automatic logic [SELW-1:0] youngest(input logic [STAGES-1:0] v);
        logic [SELW-1:0]   sel;
        logic [STAGES-1:0] t;
        sel = '0;
        t   = v;
        for (int k = 1; k <= int'(STAGES); k++) begin
            if (t[0] && (sel == '0)) sel = SELW'(k);
            t = t >> 1;
        end
        return sel;
    endfunction

    assign hi_sel = (id_valid && is_mfhi) ? youngest(hi_v) : '0;
    assign lo_sel = (id_valid && is_mflo) ? youngest(lo_v) : '0;

    // Scoreboard advance and MULT/DIV countdown
    always_comb begin
        hi_v_nxt = hi_v;
        lo_v_nxt = lo_v;
        cnt_nxt  = cnt;
        if (md_busy) begin
            // EX frozen: stage 1 holds, a bubble opens behind it
            hi_v_nxt = ((hi_v << 1) & ~(S1 | S2)) | (hi_v & S1);
            lo_v_nxt = ((lo_v << 1) & ~(S1 | S2)) | (lo_v & S1);
            cnt_nxt  = cnt - CNTW'(1);
        end else begin
            hi_v_nxt = ((hi_v << 1) & ~S1) | ((enter && dec_hi) ? S1 : '0);
            lo_v_nxt = ((lo_v << 1) & ~S1) | ((enter && dec_lo) ? S1 : '0);
            if (enter && is_mul) begin
                cnt_nxt = MUL_CNT;
            end else if (enter && is_div) begin
                cnt_nxt = DIV_CNT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hi_v <= '0;
            lo_v <= '0;
            cnt  <= '0;
        end else begin
            hi_v <= hi_v_nxt;
            lo_v <= lo_v_nxt;
            cnt  <= cnt_nxt;
        end
    end

endmodule

// File: tb/tb_hilo_hazard_ctrl.sv
// tb_hilo_hazard_ctrl: directed scenarios followed by random traffic, all
// checked against an instruction-level pipeline model of HI/LO writers.
module tb_hilo_hazard_ctrl;

    localparam int unsigned STAGES  = 3;
    localparam int unsigned MUL_LAT = 4;
    localparam int unsigned DIV_LAT = 16;
    localparam int unsigned SELW    = 2;

    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_ADD   = 6'b100000;

    logic            clk = 1'b0;
    logic            rst_n, id_valid, stall_in, flush;
    logic [5:0]      id_op, id_func;
    logic [SELW-1:0] hi_sel, lo_sel;
    logic            stall_out, md_busy;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: per-stage writer flags and remaining EX cycles of the EX occupant
    bit m_hi [1:STAGES];
    bit m_lo [1:STAGES];
    int ex_left = 0;

    logic [31:0] obs_hi, obs_lo, obs_stall;

    hilo_hazard_ctrl #(.STAGES(STAGES), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .id_valid  (id_valid),
        .id_op     (id_op),
        .id_func   (id_func),
        .stall_in  (stall_in),
        .flush     (flush),
        .hi_sel    (hi_sel),
        .lo_sel    (lo_sel),
        .stall_out (stall_out),
        .md_busy   (md_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // What an instruction writes and how long it sits in EX
    function automatic void spec_decode(input logic [5:0] op, input logic [5:0] f,
                                        output bit w_hi, output bit w_lo, output int lat);
        w_hi = 1'b0;
        w_lo = 1'b0;
        lat  = 1;
        if (op == 6'd0) begin
            case (f)
                F_MTHI:          w_hi = 1'b1;
                F_MTLO:          w_lo = 1'b1;
                F_MULT, F_MULTU: begin w_hi = 1'b1; w_lo = 1'b1; lat = MUL_LAT; end
                F_DIV, F_DIVU:   begin w_hi = 1'b1; w_lo = 1'b1; lat = DIV_LAT; end
                default:         ;
            endcase
        end
    endfunction

    // One clock: drive ID, check outputs mid-cycle, then advance the model
    task automatic cycle(input bit rst, input bit v, input logic [5:0] op,
                         input logic [5:0] f, input bit st, input bit fl);
        int  exp_h, exp_l, lat;
        bit  busy, w_hi, w_lo, go;
        @(negedge clk);
        rst_n = rst; id_valid = v; id_op = op; id_func = f; stall_in = st; flush = fl;
        #1;
        busy  = (ex_left > 1);
        exp_h = 0;
        exp_l = 0;
        for (int k = STAGES; k >= 1; k--) begin
            if (m_hi[k]) exp_h = k;
            if (m_lo[k]) exp_l = k;
        end
        if (!(v && op == 6'd0 && f == F_MFHI)) exp_h = 0;
        if (!(v && op == 6'd0 && f == F_MFLO)) exp_l = 0;
        obs_hi = 32'(hi_sel);
        obs_lo = 32'(lo_sel);
        obs_stall = 32'(stall_out);
        check("stall_out", 32'(stall_out), 32'(busy));
        check("md_busy",   32'(md_busy),   32'(busy));
        check("hi_sel",    32'(hi_sel),    32'(exp_h));
        check("lo_sel",    32'(lo_sel),    32'(exp_l));
        @(posedge clk);
        if (!rst) begin
            for (int k = 1; k <= STAGES; k++) begin m_hi[k] = 0; m_lo[k] = 0; end
            ex_left = 0;
        end else if (busy) begin
            ex_left--;
            for (int k = STAGES; k >= 3; k--) begin m_hi[k] = m_hi[k-1]; m_lo[k] = m_lo[k-1]; end
            if (STAGES >= 2) begin m_hi[2] = 0; m_lo[2] = 0; end
        end else begin
            for (int k = STAGES; k >= 2; k--) begin m_hi[k] = m_hi[k-1]; m_lo[k] = m_lo[k-1]; end
            go = v && !st && !fl;
            spec_decode(op, f, w_hi, w_lo, lat);
            m_hi[1] = go && w_hi;
            m_lo[1] = go && w_lo;
            ex_left = go ? lat : 0;
        end
    endtask

    task automatic issue(input logic [5:0] f);
        cycle(1'b1, 1'b1, 6'd0, f, 1'b0, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 6'd0, F_ADD, 1'b0, 1'b0);
    endtask

    initial begin
        logic [5:0] flist [0:8];
        logic [5:0] op, f;
        bit         rst, v, st, fl;
        flist = '{F_MFHI, F_MTHI, F_MFLO, F_MTLO, F_MULT, F_MULTU, F_DIV, F_DIVU, F_ADD};

        // 1: reset with MULT sitting in ID
        rst_n = 1'b0; id_valid = 1'b1; id_op = 6'd0; id_func = F_MULT;
        stall_in = 1'b0; flush = 1'b0;
        @(posedge clk);
        cycle(1'b0, 1'b1, 6'd0, F_MULT, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 6'd0, F_MULT, 1'b0, 1'b0);
        idle(1);
        check("rst_no_load", obs_stall, 32'd0);

        // 2: MTLO then MFLO d cycles later
        for (int d = 1; d <= 4; d++) begin
            issue(F_MTLO);
            idle(d - 1);
            issue(F_MFLO);
            check("mflo_dist_lo", obs_lo, (d <= 3) ? 32'(d) : 32'd0);
            check("mflo_dist_hi", obs_hi, 32'd0);
            idle(4);
        end

        // 3: MULT followed by MFHI waiting out the stall
        issue(F_MULT);
        for (int i = 0; i < 3; i++) begin
            issue(F_MFHI);
            check("mult_stall", obs_stall, 32'd1);
            check("mult_stall_hi", obs_hi, 32'd1);
        end
        issue(F_MFHI);
        check("mult_done_stall", obs_stall, 32'd0);
        check("mult_done_hi", obs_hi, 32'd1);
        issue(F_MFHI);
        check("mult_bubble_hi", obs_hi, 32'd2);
        idle(4);

        // 4: youngest writer wins
        issue(F_MTHI);
        issue(F_MTLO);
        issue(F_MULTU);
        issue(F_MFHI);
        check("young_hi_stall", obs_stall, 32'd1);
        check("young_hi_sel", obs_hi, 32'd1);
        cycle(1'b1, 1'b1, 6'd0, F_MFHI, 1'b0, 1'b0);
        idle(6);
        issue(F_MTHI);
        issue(F_MTLO);
        idle(1);
        issue(F_MFLO);
        check("young_lo_sel", obs_lo, 32'd2);
        idle(4);

        // 5: flushed DIV and stalled MTHI never enter the scoreboard
        cycle(1'b1, 1'b1, 6'd0, F_DIV, 1'b0, 1'b1);
        idle(1);
        check("flush_div_stall", obs_stall, 32'd0);
        cycle(1'b1, 1'b1, 6'd0, F_MTHI, 1'b1, 1'b0);
        issue(F_MFHI);
        check("stalled_mthi_hi", obs_hi, 32'd0);
        idle(4);

        // 6: reset in the middle of a DIV
        issue(F_DIV);
        idle(6);
        cycle(1'b0, 1'b0, 6'd0, F_ADD, 1'b0, 1'b0);
        issue(F_MFLO);
        check("div_rst_stall", obs_stall, 32'd0);
        check("div_rst_lo", obs_lo, 32'd0);
        idle(4);

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            rst = ($urandom_range(0, 99) != 0);
            v   = ($urandom_range(0, 3) != 0);
            st  = ($urandom_range(0, 7) == 0);
            fl  = ($urandom_range(0, 7) == 0);
            op  = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(1, 63)) : 6'd0;
            f   = ($urandom_range(0, 9) == 0) ? 6'($urandom) : flist[$urandom_range(0, 8)];
            // Keep long DIV stalls from dominating the run
            if ((f == F_DIV || f == F_DIVU) && $urandom_range(0, 2) != 0) f = F_MFHI;
            cycle(rst, v, op, f, st, fl);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/hilo_hazard_ctrl.md
Name: hilo_hazard_ctrl

Overview:
Parametrised successor to the HI/LO forwarding selector. It owns the pipelined scoreboard of HI/LO writers, so decode info is carried internally through STAGES post-ID stages. It also adds multi-cycle MULT/DIV busy tracking with stall generation. It sits beside the ID stage: it drives the HI/LO operand bypass muxes for MFHI/MFLO and a stall to the pipeline control.

Parameters:
STAGES, 3, number of post-ID stages tracked (1=EX, 2=MEM, 3=WB, ...); legal 1..7
MUL_LAT, 4, cycles a MULT/MULTU occupies EX; legal 1..64
DIV_LAT, 16, cycles a DIV/DIVU occupies EX; legal 1..64
(derived localparam SELW = clog2(STAGES+1), minimum 1)

Ports:
clk  in  1  clock; all state changes on rising edge
rst_n  in  1  reset, synchronous, active-low
id_valid  in  1  ID holds a real instruction
id_op  in  6  ID opcode
id_func  in  6  ID funct
stall_in  in  1  external ID stall (e.g. load-use); holds ID only
flush  in  1  kill ID instruction (branch/exception); ID content does not enter EX
hi_sel  out  SELW  HI bypass select for the ID instruction: 0=HI register, k=stage k result
lo_sel  out  SELW  LO bypass select for the ID instruction: 0=LO register, k=stage k result
stall_out  out  1  freeze ID and EX; equals md_busy
md_busy  out  1  multi-cycle MULT/DIV still executing in EX

Behaviour:
- Decode, all with op=000000: MFHI f=010000, MTHI 010001, MFLO 010010, MTLO 010011, MULT 011000, MULTU 011001, DIV 011010, DIVU 011011.
- HI writers: MTHI, MULT*, DIV*. LO writers: MTLO, MULT*, DIV*. Any other op/func is not a writer.
- State:
  - per-stage flags hi_v[k], lo_v[k] for k=1..STAGES
  - down-counter cnt, 6 bits
- md_busy = (cnt != 0). stall_out = md_busy. No other stall source.
- Per-cycle update when rst_n=1 (precedence top to bottom):
  - md_busy=1: stage1 holds its flags; stage2 <= bubble (zeros); stages 3..STAGES shift from k-1; cnt <= cnt-1.
  - else if stall_in=1 or flush=1 or id_valid=0: stage1 <= bubble; stages 2..STAGES shift.
  - else: stage1 <= decoded writer flags of ID; stages 2..STAGES shift.
  - If a MULT*/DIV* enters stage1 in that cycle, cnt <= MUL_LAT-1 or DIV_LAT-1 respectively. With LAT=1, cnt stays 0 and there is no busy.
- Resulting occupancy: a MULT/DIV occupies EX for exactly LAT cycles. Its result is valid on the final EX cycle (cnt==0).
- STAGES=1: no shift stages exist. The bubble/shift rules reduce to stage1 alone.
- hi_sel, combinational from state and ID inputs:
  - if id_valid and ID=MFHI: hi_sel = smallest k with hi_v[k]=1 (youngest writer wins), else 0.
  - if ID is not MFHI: hi_sel = 0.
- lo_sel: identical rule using MFLO and lo_v.
- Sel values are driven even while stall_out=1. Datapath consumes them once stall_out=0.
- flush does not affect an in-flight cnt. Only the ID instruction is killed.
- Reset: rst_n=0 at a rising edge clears all hi_v/lo_v and cnt, including mid-MULT/DIV. After that edge:
  - stall_out=md_busy=0
  - hi_sel=lo_sel=0 (unless ID is MFHI/MFLO with no writers, which also yields 0)
- No X on outputs after the first reset edge.

Test Plan:
1. Reset with MULT in ID, rst_n=0 for 2 cycles -> stall_out=0, md_busy=0, hi_sel=lo_sel=0; no counter load.
2. Defaults. MTLO issued, then MFLO presented in ID 1/2/3/4 cycles later -> lo_sel=1/2/3/0; hi_sel=0 throughout.
3. MULT issued, MFHI next in ID -> stall_out=1 for 3 cycles with hi_sel=1 and lo_sel=0 (ID is MFHI). Next cycle: stall_out=0, hi_sel=1, MFHI advances. One cycle later the MULT flags are in stage2, not stage3 (bubble inserted behind it).
4. Youngest-wins. Sequence MTHI, MTLO, MULTU, then MFHI and then MFLO in ID:
   - while MFHI is in ID (MULTU in EX, cnt=3) -> hi_sel=1 during the stall;
   - with MTHI in stage3 and MTLO in stage2 but no MULT, MFLO -> lo_sel=2.
5. DIV in ID with flush=1 -> cnt stays 0, stall_out=0, stage1 bubble. MTHI in ID with stall_in=1 -> stage1 bubble; MFHI next cycle -> hi_sel=0.
6. DIV issued, rst_n=0 when cnt=9 -> next cycle stall_out=0, md_busy=0, all flags clear. MFLO then yields lo_sel=0.
